// File: rtl/lsu_ctrl_if.sv
// lsu_ctrl_if: request/response handshake and word-wide dmem bus of the load/store controller
interface lsu_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_we;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;
    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rd,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_a, mem_wd
    );
    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rd,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_a, mem_wd
    );
endinterface

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: byte/half/word load-store controller with read-modify-write sub-word stores.
// Define MISALIGN_TRAP_EN to report misaligned accesses as errors instead of aligning them down.
module lsu_ctrl #(
    parameter int DEPTH_WORDS = 64
) (
    input logic       clk,
    input logic       reset,
    lsu_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;
    state_t state, state_nx;
    logic        we_q, sgn_q, err_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q, wdata_q, word_q;
    logic        acc, oor, bad;
    logic [31:0] a_al;
    logic [4:0]  sh;
    logic [31:0] mask, merged, ext;
    logic [15:0] lane;
    assign acc = bus.req_valid & (state == IDLE);
    assign oor = bus.req_addr[31:2] >= 30'(DEPTH_WORDS);
`ifdef MISALIGN_TRAP_EN
    logic mis;
    assign mis  = (bus.req_size == 2'd1 & bus.req_addr[0]) | (bus.req_size == 2'd2 & |bus.req_addr[1:0]);
    assign bad  = (bus.req_size == 2'd3) | oor | mis;
    assign a_al = bus.req_addr;
`else
    assign bad  = (bus.req_size == 2'd3) | oor;
    assign a_al = {bus.req_addr[31:2], bus.req_size == 2'd2 ? 2'b00
                  : {bus.req_addr[1], bus.req_size == 2'd1 ? 1'b0 : bus.req_addr[0]}};
`endif
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else       state <= state_nx;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = !acc ? IDLE : bad ? RESP
                              : (bus.req_we && bus.req_size == 2'd2) ? WR : RD;
            RD:      state_nx = we_q ? WR : RESP;
            WR:      state_nx = RESP;
            default: state_nx = IDLE;
        endcase
    end
    // Request fields are frozen at acceptance; word_q holds the dmem word read in RD.
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            we_q    <= 1'b0;
            sgn_q   <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= 2'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            word_q  <= '0;
        end else begin
            if (acc) begin
                we_q    <= bus.req_we;
                sgn_q   <= bus.req_signed;
                err_q   <= bad;
                size_q  <= bus.req_size;
                addr_q  <= a_al;
                wdata_q <= bus.req_wdata;
            end
            if (state == RD) word_q <= bus.mem_rd;
        end
    always_comb begin
        sh     = size_q == 2'd0 ? {addr_q[1:0], 3'b000} : {addr_q[1], 4'b0000};
        mask   = (size_q == 2'd0 ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
        merged = size_q == 2'd2 ? wdata_q : (word_q & ~mask) | ((wdata_q << sh) & mask);
        lane   = 16'(word_q >> sh);
        ext    = size_q == 2'd0 ? {{24{sgn_q & lane[7]}}, lane[7:0]}
               : size_q == 2'd1 ? {{16{sgn_q & lane[15]}}, lane}
               : word_q;
        bus.req_ready  = state == IDLE;
        bus.resp_valid = state == RESP;
        bus.resp_err   = state == RESP & err_q;
        bus.resp_rdata = (state == RESP & !we_q & !err_q) ? ext : '0;
        bus.mem_we     = state == WR;
        bus.mem_a      = (state == RD || state == WR) ? {addr_q[31:2], 2'b00} : '0;
        bus.mem_wd     = state == WR ? merged : '0;
    end
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed vector table plus hand sequences for lsu_ctrl against a word memory model
module tb_lsu_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    lsu_ctrl_if bus ();
    lsu_ctrl #(.DEPTH_WORDS(64)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
    logic [31:0] mem [64];
    assign bus.mem_rd = mem[bus.mem_a[7:2]];
    always @(posedge clk) if (bus.mem_we) mem[bus.mem_a[7:2]] <= bus.mem_wd;
    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        int          wcyc;
        logic [31:0] wa;
        logic [31:0] wd;
        logic [31:0] rdata;
        logic        err;
    } vec_t;
    vec_t vq[$];
    int n_cmp = 0;
    int n_bad = 0;
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask
    task automatic run(input int id, input vec_t v);
        int rc = 0, wc = 0;
        logic [31:0] wd = '0, wa = '0, rd = '0;
        logic er = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = v.we; bus.req_size = v.size;
        bus.req_signed = v.sgn; bus.req_addr = v.addr; bus.req_wdata = v.wdata;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0; bus.req_we = ~v.we; bus.req_signed = ~v.sgn;
        bus.req_addr = ~v.addr; bus.req_wdata = ~v.wdata;
        for (int k = 1; k <= 6 && rc == 0; k++) begin
            @(negedge clk);
            if (k == 1) chk($sformatf("v%0d busy_ready", id), 32'(bus.req_ready), 32'd0);
            if (bus.mem_we && wc == 0) begin wc = k; wd = bus.mem_wd; wa = bus.mem_a; end
            if (bus.resp_valid) begin rc = k; rd = bus.resp_rdata; er = bus.resp_err; end
        end
        chk($sformatf("v%0d resp_cycle", id), 32'(rc), 32'(v.lat));
        chk($sformatf("v%0d rdata", id), rd, v.rdata);
        chk($sformatf("v%0d err", id), 32'(er), 32'(v.err));
        chk($sformatf("v%0d write_cycle", id), 32'(wc), 32'(v.wcyc));
        if (v.wcyc != 0) begin
            chk($sformatf("v%0d mem_wd", id), wd, v.wd);
            chk($sformatf("v%0d mem_a", id), wa, v.wa);
        end
        @(negedge clk);
        chk($sformatf("v%0d idle_ready", id), 32'(bus.req_ready), 32'd1);
    endtask
    initial begin
        bool_init: begin
            bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'd0;
            bus.req_signed = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        end
        vq.push_back('{1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 2, 1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0});
        vq.push_back('{1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 2, 0, 32'h0, 32'h0, 32'hDEADBEEF, 1'b0});
        vq.push_back('{1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 2, 0, 32'h0, 32'h0, 32'hFFFFFFDE, 1'b0});
        vq.push_back('{1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 2, 0, 32'h0, 32'h0, 32'h000000DE, 1'b0});
        vq.push_back('{1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 2, 0, 32'h0, 32'h0, 32'hFFFFDEAD, 1'b0});
        vq.push_back('{1'b0, 2'd1, 1'b0, 32'h10, 32'h0, 2, 0, 32'h0, 32'h0, 32'h0000BEEF, 1'b0});
        vq.push_back('{1'b0, 2'd0, 1'b1, 32'h10, 32'h0, 2, 0, 32'h0, 32'h0, 32'hFFFFFFEF, 1'b0});
        vq.push_back('{1'b1, 2'd0, 1'b0, 32'h11, 32'hAAAAAA55, 3, 2, 32'h10, 32'hDEAD55EF, 32'h0, 1'b0});
        vq.push_back('{1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 2, 0, 32'h0, 32'h0, 32'hDEAD55EF, 1'b0});
        vq.push_back('{1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 1, 0, 32'h0, 32'h0, 32'h0, 1'b1});
        vq.push_back('{1'b1, 2'd2, 1'b0, 32'h100, 32'h12345678, 1, 0, 32'h0, 32'h0, 32'h0, 1'b1});
        vq.push_back('{1'b0, 2'd3, 1'b0, 32'h10, 32'h0, 1, 0, 32'h0, 32'h0, 32'h0, 1'b1});
        vq.push_back('{1'b1, 2'd2, 1'b0, 32'h20, 32'h12345678, 2, 1, 32'h20, 32'h12345678, 32'h0, 1'b0});
`ifdef MISALIGN_TRAP_EN
        vq.push_back('{1'b1, 2'd1, 1'b0, 32'h21, 32'hCAFEBEEF, 1, 0, 32'h0, 32'h0, 32'h0, 1'b1});
        vq.push_back('{1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 2, 0, 32'h0, 32'h0, 32'h12345678, 1'b0});
        vq.push_back('{1'b0, 2'd2, 1'b0, 32'h11, 32'h0, 1, 0, 32'h0, 32'h0, 32'h0, 1'b1});
`else
        vq.push_back('{1'b1, 2'd1, 1'b0, 32'h21, 32'hCAFEBEEF, 3, 2, 32'h20, 32'h1234BEEF, 32'h0, 1'b0});
        vq.push_back('{1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 2, 0, 32'h0, 32'h0, 32'h1234BEEF, 1'b0});
        vq.push_back('{1'b0, 2'd2, 1'b0, 32'h11, 32'h0, 2, 0, 32'h0, 32'h0, 32'hDEAD55EF, 1'b0});
`endif
        vq.push_back('{1'b0, 2'd1, 1'b1, 32'h22, 32'h0, 2, 0, 32'h0, 32'h0, 32'h00001234, 1'b0});
        vq.push_back('{1'b1, 2'd2, 1'b0, 32'hFC, 32'h80000001, 2, 1, 32'hFC, 32'h80000001, 32'h0, 1'b0});
        vq.push_back('{1'b0, 2'd0, 1'b1, 32'hFF, 32'h0, 2, 0, 32'h0, 32'h0, 32'hFFFFFF80, 1'b0});
        vq.push_back('{1'b1, 2'd1, 1'b0, 32'hFE, 32'h00008001, 3, 2, 32'hFC, 32'h80010001, 32'h0, 1'b0});
        vq.push_back('{1'b0, 2'd2, 1'b0, 32'hFC, 32'h0, 2, 0, 32'h0, 32'h0, 32'h80010001, 1'b0});
        vq.push_back('{1'b1, 2'd2, 1'b0, 32'h30, 32'h11111111, 2, 1, 32'h30, 32'h11111111, 32'h0, 1'b0});
        repeat (2) @(negedge clk);
        chk("rst req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst resp_rdata", bus.resp_rdata, 32'd0);
        chk("rst resp_err", 32'(bus.resp_err), 32'd0);
        chk("rst mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst mem_a", bus.mem_a, 32'd0);
        chk("rst mem_wd", bus.mem_wd, 32'd0);
        reset = 1'b0;
        foreach (vq[i]) run(i, vq[i]);
        // Reset lands while a byte store is in WR: no commit, no response.
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'd0;
        bus.req_signed = 1'b0; bus.req_addr = 32'h30; bus.req_wdata = 32'h99;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("mid mem_we", 32'(bus.mem_we), 32'd1);
        chk("mid mem_wd", bus.mem_wd, 32'h11111199);
        reset = 1'b1;
        #1;
        chk("async mem_we", 32'(bus.mem_we), 32'd0);
        chk("async req_ready", 32'(bus.req_ready), 32'd1);
        chk("async mem_a", bus.mem_a, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        begin
            logic seen = 1'b0;
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                if (bus.resp_valid) seen = 1'b1;
            end
            chk("no resp after reset", 32'(seen), 32'd0);
        end
        run(99, '{1'b0, 2'd2, 1'b0, 32'h30, 32'h0, 2, 0, 32'h0, 32'h0, 32'h11111111, 1'b0});
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
